// File: rtl/gshare_pht.sv
// gshare pattern history table.
// Fetch PC bits are XORed with the global history word to index a table of
// 2-bit saturating counters. A registered prediction and its index come back
// one cycle later. At resolve, the counter is updated and the history shift
// register is driven, and mispredicts are counted.
//
// Handshake: predict_valid and update_valid are single-cycle qualifiers with
// no backpressure. A request is accepted on every rising edge where its valid
// is high. pred_valid is the one-cycle-delayed copy of predict_valid.
// Updates are only honoured once ready is high.
module gshare_pht #(
  parameter int hist_width = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [hist_width-1:0] history,
  input  logic                  predict_valid,
  input  logic [31:0]           predict_pc,
  output logic                  pred_valid,
  output logic                  pred_taken,
  output logic [hist_width-1:0] pred_index,
  input  logic                  update_valid,
  input  logic [hist_width-1:0] update_index,
  input  logic                  update_taken,
  input  logic                  update_mispredict,
  output logic                  hist_load,
  output logic                  hist_in,
  output logic                  ready,
  output logic [31:0]           mispredict_count,
  output logic                  state_dbg
);

  localparam int entries = 1 << hist_width;

  // st_init sweeps the table to weak-not-taken; st_run predicts and updates.
  typedef enum logic {
    st_init = 1'b0,
    st_run  = 1'b1
  } state_t;

  state_t                state;
  logic [hist_width-1:0] ptr;
  logic [1:0]            pht [entries];

  logic [hist_width-1:0] idx;
  logic [1:0]            upd_old;
  logic [1:0]            upd_new;
  logic [1:0]            pred_ctr;
  logic                  upd_en;

  // The PC bits outside the index field are intentionally unused.
  logic unused_pc;
  assign unused_pc = ^{predict_pc[31:hist_width+2], predict_pc[1:0]};

  // Index computation, saturating counter step, and same-cycle forwarding.
  always_comb begin
    idx     = predict_pc[hist_width+1:2] ^ history;
    upd_old = pht[update_index];
    upd_new = upd_old;
    if (update_taken) begin
      if (upd_old != 2'b11) upd_new = upd_old + 2'd1;
    end else begin
      if (upd_old != 2'b00) upd_new = upd_old - 2'd1;
    end
    upd_en   = update_valid & (state == st_run);
    pred_ctr = (upd_en && (update_index == idx)) ? upd_new : pht[idx];
  end

  // Single table write port: the init sweep during st_init, else resolve updates.
  // The table itself is not reset; the sweep after every reset re-initialises it.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (state == st_init) begin
        pht[ptr] <= 2'b01;
      end else if (upd_en) begin
        pht[update_index] <= upd_new;
      end
    end
  end

  // Init/run FSM with the sweep pointer; leaves st_init after the last entry.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= st_init;
      ptr   <= '0;
    end else begin
      case (state)
        st_init: begin
          ptr <= ptr + 1'b1;
          if (ptr == {hist_width{1'b1}}) state <= st_run;
        end
        st_run:  state <= st_run;
        default: state <= st_init;
      endcase
    end
  end

  // Registered prediction; taken is forced low until the table is initialised.
  always_ff @(posedge clk) begin
    if (reset) begin
      pred_valid <= 1'b0;
      pred_taken <= 1'b0;
      pred_index <= '0;
    end else begin
      pred_valid <= predict_valid;
      pred_index <= idx;
      pred_taken <= (state == st_run) & pred_ctr[1];
    end
  end

  // Saturating mispredict counter, cleared only by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      mispredict_count <= '0;
    end else if (upd_en && update_mispredict && (mispredict_count != 32'hFFFF_FFFF)) begin
      mispredict_count <= mispredict_count + 32'd1;
    end
  end

  assign ready     = (state == st_run);
  assign hist_load = update_valid & ready;
  assign hist_in   = update_taken;
  assign state_dbg = (state == st_run);

endmodule

// File: tb/tb_gshare_pht.sv
// Testbench for gshare_pht: directed walk through the predictor behaviour
// followed by randomized predict/update traffic against a table model.
module tb_gshare_pht;

  localparam int W = 8;
  localparam int N = 1 << W;

  logic          clk;
  logic          reset;
  logic [W-1:0]  history;
  logic          predict_valid;
  logic [31:0]   predict_pc;
  logic          pred_valid;
  logic          pred_taken;
  logic [W-1:0]  pred_index;
  logic          update_valid;
  logic [W-1:0]  update_index;
  logic          update_taken;
  logic          update_mispredict;
  logic          hist_load;
  logic          hist_in;
  logic          ready;
  logic [31:0]   mispredict_count;
  logic          state_dbg;

  gshare_pht #(.hist_width(W)) dut (
    .clk               (clk),
    .reset             (reset),
    .history           (history),
    .predict_valid     (predict_valid),
    .predict_pc        (predict_pc),
    .pred_valid        (pred_valid),
    .pred_taken        (pred_taken),
    .pred_index        (pred_index),
    .update_valid      (update_valid),
    .update_index      (update_index),
    .update_taken      (update_taken),
    .update_mispredict (update_mispredict),
    .hist_load         (hist_load),
    .hist_in           (hist_in),
    .ready             (ready),
    .mispredict_count  (mispredict_count),
    .state_dbg         (state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- model and scoreboard state ----------------
  int          n_vec;
  int          n_err;
  int          init_cnt;          // cycles with reset low since last reset
  int          m_tbl [N];         // counter value 0..3 per entry
  logic [31:0] m_mis;
  logic [W+1:0] exp_q [$];        // {pred_valid, pred_taken, pred_index}

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    reset             = 1'b1;
    predict_valid     = 1'b0;
    predict_pc        = '0;
    history           = '0;
    update_valid      = 1'b0;
    update_index      = '0;
    update_taken      = 1'b0;
    update_mispredict = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    init_cnt = 0;
    m_mis    = '0;
    for (int i = 0; i < N; i++) m_tbl[i] = 1;
    exp_q.delete();
    check("rst_pred_valid", pred_valid, 0);
    check("rst_pred_taken", pred_taken, 0);
    check("rst_pred_index", pred_index, 0);
    check("rst_ready", ready, 0);
    check("rst_mis_count", mispredict_count, 0);
    check("rst_hist_load", hist_load, 0);
  endtask

  // One clock cycle of stimulus; model is advanced and outputs checked.
  task automatic step(input logic pv, input logic [31:0] pc, input logic [W-1:0] hist,
                      input logic uv, input logic [W-1:0] ui, input logic ut, input logic um);
    logic         rdy;
    logic [W-1:0] idx;
    logic [W+1:0] exp;
    logic         exp_taken;
    predict_valid     = pv;
    predict_pc        = pc;
    history           = hist;
    update_valid      = uv;
    update_index      = ui;
    update_taken      = ut;
    update_mispredict = um;
    #1;
    rdy = (init_cnt >= N);
    check("hist_load", hist_load, uv & rdy);
    check("hist_in", hist_in, ut);
    // resolve first, so a same-cycle prediction sees the updated counter
    if (rdy && uv) begin
      if (ut) m_tbl[ui] = (m_tbl[ui] < 3) ? m_tbl[ui] + 1 : 3;
      else    m_tbl[ui] = (m_tbl[ui] > 0) ? m_tbl[ui] - 1 : 0;
      if (um && m_mis != 32'hFFFF_FFFF) m_mis = m_mis + 1;
    end
    idx = pc[W+1:2] ^ hist;
    exp_taken = rdy && (m_tbl[idx] >= 2);
    exp_q.push_back({pv, exp_taken, idx});
    if (init_cnt < N) init_cnt++;
    @(negedge clk);
    exp = exp_q.pop_front();
    check("pred_valid", pred_valid, exp[W+1]);
    check("pred_taken", pred_taken, exp[W]);
    check("pred_index", pred_index, exp[W-1:0]);
    check("ready", ready, init_cnt >= N);
    check("state_dbg", state_dbg, init_cnt >= N);
    check("mis_count", mispredict_count, m_mis);
  endtask

  task automatic idle();
    step(1'b0, 32'h0, '0, 1'b0, '0, 1'b0, 1'b0);
  endtask

  task automatic predict_at(input logic [W-1:0] target);
    logic [31:0] pc;
    pc = {22'd0, target, 2'b00};
    step(1'b1, pc, '0, 1'b0, '0, 1'b0, 1'b0);
  endtask

  task automatic update_at(input logic [W-1:0] target, input logic taken, input logic mis);
    step(1'b0, 32'h0, '0, 1'b1, target, taken, mis);
  endtask

  // Init sweep with random traffic; updates must be ignored throughout.
  task automatic run_init(input int cycles);
    logic [31:0] pc;
    for (int i = 0; i < cycles; i++) begin
      pc = $urandom;
      step($urandom_range(0, 1), pc, W'($urandom), $urandom_range(0, 1),
           W'($urandom), $urandom_range(0, 1), $urandom_range(0, 1));
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [31:0]  pc;
    logic [W-1:0] hist;
    logic [W-1:0] t;
    n_vec = 0;
    n_err = 0;
    init_cnt = 0;
    m_mis = '0;
    for (int i = 0; i < N; i++) m_tbl[i] = 1;

    do_reset();
    // reset mid-init, then a full init with random (ignored) updates
    run_init(100);
    do_reset();
    run_init(N);
    check("ready_at_256", ready, 1);

    // index formation
    step(1'b1, 32'h0000_0040, 8'h00, 1'b0, '0, 1'b0, 1'b0);
    check("idx_hist00", pred_index, 8'h10);
    check("weak_nt_after_init", pred_taken, 0);
    step(1'b1, 32'h0000_0040, 8'hFF, 1'b0, '0, 1'b0, 1'b0);
    check("idx_histff", pred_index, 8'hEF);

    // counter walk at 0x10
    update_at(8'h10, 1'b1, 1'b0);
    predict_at(8'h10);
    check("walk_t1", pred_taken, 1);
    for (int i = 0; i < 3; i++) update_at(8'h10, 1'b1, 1'b0);
    predict_at(8'h10);
    check("walk_t4", pred_taken, 1);
    update_at(8'h10, 1'b0, 1'b0);
    predict_at(8'h10);
    check("walk_nt1", pred_taken, 1);
    for (int i = 0; i < 3; i++) update_at(8'h10, 1'b0, 1'b0);
    predict_at(8'h10);
    check("walk_nt4", pred_taken, 0);

    // same-cycle forwarding at 0x20 from weak NT
    step(1'b1, 32'h0000_0080, 8'h00, 1'b1, 8'h20, 1'b1, 1'b0);
    check("fwd_taken", pred_taken, 1);

    // hist_load in run
    predict_valid = 1'b0;
    update_valid  = 1'b1;
    update_taken  = 1'b1;
    update_index  = 8'h30;
    #1;
    check("hist_load_run", hist_load, 1);
    check("hist_in_run", hist_in, 1);
    @(negedge clk);
    m_tbl[8'h30] = 2;
    update_valid = 1'b0;

    // mispredict counting
    for (int i = 0; i < 3; i++) update_at(8'h40, 1'b0, 1'b1);
    check("mis_count_3", mispredict_count, 3);

    // randomized traffic on a small index window for collisions and saturation
    for (int i = 0; i < 2000; i++) begin
      hist = W'($urandom);
      t    = W'($urandom_range(0, 7));
      pc   = $urandom;
      pc[W+1:2] = t ^ hist;
      step($urandom_range(0, 1), pc, hist, $urandom_range(0, 1),
           W'($urandom_range(0, 7)), $urandom_range(0, 1), $urandom_range(0, 1));
    end

    // reset mid-run: full re-init, every entry back to weak NT
    do_reset();
    run_init(N);
    for (int i = 0; i < N; i++) predict_at(W'(i));
    update_at(8'h55, 1'b1, 1'b0);
    predict_at(8'h55);
    check("reinit_weak_nt", pred_taken, 1);
    idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
